// File: rtl/strassen_mm2x2_acc.sv
// strassen_mm2x2_acc: four-stage 2x2 Strassen tile multiplier with saturating
// accumulation across a first/last-framed group of tiles, valid/ready on both sides.
module strassen_mm2x2_acc #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ACCWIDTH  = 2 * DATAWIDTH + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*DATAWIDTH-1:0] A,
    input  logic [4*DATAWIDTH-1:0] B,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   in_half,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*ACCWIDTH-1:0]  C_out,
    output logic                   ovf
);
    localparam int unsigned PreW  = DATAWIDTH + 1;
    localparam int unsigned ProdW = 2 * DATAWIDTH + 2;
    localparam int unsigned PostW = 2 * DATAWIDTH + 4;
    // One guard bit above whichever of acc/post-add is wider, so the sum never wraps
    localparam int unsigned SumW  = ((ACCWIDTH > PostW) ? ACCWIDTH : PostW) + 1;
    localparam logic [SumW-1:0] MaxAcc = {{(SumW-ACCWIDTH+1){1'b0}}, {(ACCWIDTH-1){1'b1}}};
    localparam logic [SumW-1:0] MinAcc = {{(SumW-ACCWIDTH+1){1'b1}}, {(ACCWIDTH-1){1'b0}}};

    logic                     w_en, w_accept;
    logic [3:0][PreW-1:0]     w_a, w_b;
    logic [6:0][PreW-1:0]     w_t, w_s, r_t, r_s;
    logic [6:0][ProdW-1:0]    w_m, r_m;
    logic [6:0][PostW-1:0]    w_me;
    logic [3:0][PostW-1:0]    w_p, r_p;
    logic [3:0][SumW-1:0]     w_sum;
    logic [3:0]               w_hi, w_lo;
    logic [3:0][ACCWIDTH-1:0] w_acc_nxt, r_acc, r_cout;
    logic                     w_ovf_nxt;
    logic                     r_v1, r_first1, r_last1, r_half1;
    logic                     r_v2, r_first2, r_last2, r_half2;
    logic                     r_v3, r_first3, r_last3;
    logic                     r_ovf_acc, r_ovf, r_out_valid;

    // A pending result that is not being taken freezes the whole pipeline
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = rst && w_en;
    assign w_accept = in_valid && in_ready;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign w_a[g] = {A[g*DATAWIDTH+DATAWIDTH-1], A[g*DATAWIDTH +: DATAWIDTH]};
        assign w_b[g] = {B[g*DATAWIDTH+DATAWIDTH-1], B[g*DATAWIDTH +: DATAWIDTH]};
    end

    assign w_t[0] = w_a[0] + w_a[3];
    assign w_t[1] = w_a[2] + w_a[3];
    assign w_t[2] = w_a[0];
    assign w_t[3] = w_a[3];
    assign w_t[4] = w_a[0] + w_a[1];
    assign w_t[5] = w_a[2] - w_a[0];
    assign w_t[6] = w_a[1] - w_a[3];
    assign w_s[0] = w_b[0] + w_b[3];
    assign w_s[1] = w_b[0];
    assign w_s[2] = w_b[1] - w_b[3];
    assign w_s[3] = w_b[2] - w_b[0];
    assign w_s[4] = w_b[3];
    assign w_s[5] = w_b[0] + w_b[1];
    assign w_s[6] = w_b[2] + w_b[3];

    // Products computed modulo 2^ProdW on sign-extended operands are exact
    for (genvar g = 0; g < 7; g++) begin : g_mul
        localparam bit Kill = (g == 0) || (g == 5) || (g == 6);
        assign w_m[g] = (Kill && r_half1) ? '0 :
            {{(ProdW-PreW){r_t[g][PreW-1]}}, r_t[g]} * {{(ProdW-PreW){r_s[g][PreW-1]}}, r_s[g]};
        assign w_me[g] = {{2{r_m[g][ProdW-1]}}, r_m[g]};
    end

    assign w_p[0] = r_half2 ? '0 : w_me[0] + w_me[3] - w_me[4] + w_me[6];
    assign w_p[1] = w_me[2] + w_me[4];
    assign w_p[2] = w_me[1] + w_me[3];
    assign w_p[3] = r_half2 ? '0 : w_me[0] - w_me[1] + w_me[2] + w_me[5];

    for (genvar g = 0; g < 4; g++) begin : g_acc
        assign w_sum[g] = (r_first3 ? '0 : {{(SumW-ACCWIDTH){r_acc[g][ACCWIDTH-1]}}, r_acc[g]})
                        + {{(SumW-PostW){r_p[g][PostW-1]}}, r_p[g]};
        assign w_hi[g] = $signed(w_sum[g]) > $signed(MaxAcc);
        assign w_lo[g] = $signed(w_sum[g]) < $signed(MinAcc);
        assign w_acc_nxt[g] = w_hi[g] ? MaxAcc[ACCWIDTH-1:0] :
                              w_lo[g] ? MinAcc[ACCWIDTH-1:0] : w_sum[g][ACCWIDTH-1:0];
    end

    // A first beat restarts the sticky flag from this beat's clamps only
    assign w_ovf_nxt = (!r_first3 && r_ovf_acc) || (|w_hi) || (|w_lo);

    // Stage 1: register pre-added operand pairs and beat flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1 <= 1'b0; r_first1 <= 1'b0; r_last1 <= 1'b0; r_half1 <= 1'b0;
            r_t  <= '0;   r_s      <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept; r_first1 <= in_first; r_last1 <= in_last; r_half1 <= in_half;
            r_t  <= w_t;      r_s      <= w_s;
        end
    end

    // Stage 2: register the seven Strassen products
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v2 <= 1'b0; r_first2 <= 1'b0; r_last2 <= 1'b0; r_half2 <= 1'b0;
            r_m  <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1; r_first2 <= r_first1; r_last2 <= r_last1; r_half2 <= r_half1;
            r_m  <= w_m;
        end
    end

    // Stage 3: register the post-added tile product
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v3 <= 1'b0; r_first3 <= 1'b0; r_last3 <= 1'b0;
            r_p  <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2; r_first3 <= r_first2; r_last3 <= r_last2;
            r_p  <= w_p;
        end
    end

    // Stage 4: saturating accumulate; a last beat publishes the group result
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0; r_ovf_acc <= 1'b0; r_cout <= '0; r_ovf <= 1'b0; r_out_valid <= 1'b0;
        end else if (w_en) begin
            if (r_v3) begin
                r_acc     <= w_acc_nxt;
                r_ovf_acc <= w_ovf_nxt;
            end
            if (r_v3 && r_last3) begin
                r_cout <= w_acc_nxt;
                r_ovf  <= w_ovf_nxt;
            end
            // en=1 means any held result is being taken this cycle
            r_out_valid <= r_v3 && r_last3;
        end
    end

    assign C_out     = {r_cout[3], r_cout[2], r_cout[1], r_cout[0]};
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_strassen_mm2x2_acc.sv
// Bench for strassen_mm2x2_acc: table vectors, hand sequences and a random
// valid/ready run, all scored against a direct matrix-product model.
module tb_strassen_mm2x2_acc;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 17;
    localparam int unsigned NW = 16;
    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW - 1));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        half;
        longint      c3, c2, c1, c0;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [4*AW-1:0] c;
        logic            ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, in_half = 1'b0;
    logic out_ready = 1'b1;
    logic [4*DW-1:0] A = '0, B = '0;
    logic in_ready, out_valid, ovf;
    logic [4*AW-1:0] C_out;
    logic nar_in_ready, nar_out_valid, nar_ovf;
    logic [4*NW-1:0] nar_c;

    logic ready_ctl = 1'b1;
    logic rnd_mode  = 1'b0;
    int n_checks = 0, n_fail = 0, n_out = 0, n_ov_cycles = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    longint m_acc [4];
    logic m_ovf = 1'b0;
    logic stall_prev = 1'b0, ovf_prev = 1'b0;
    logic [4*AW-1:0] c_prev = '0;
    vec_t tbl [8];

    strassen_mm2x2_acc #(.DATAWIDTH(DW), .ACCWIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .in_first(in_first), .in_last(in_last), .in_half(in_half), .out_valid(out_valid),
        .out_ready(out_ready), .C_out(C_out), .ovf(ovf)
    );

    strassen_mm2x2_acc #(.DATAWIDTH(DW), .ACCWIDTH(NW)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nar_in_ready), .A(A), .B(B),
        .in_first(in_first), .in_last(in_last), .in_half(in_half), .out_valid(nar_out_valid),
        .out_ready(out_ready), .C_out(nar_c), .ovf(nar_ovf)
    );

    always #5 clk = ~clk;

    // Downstream ready: scripted or random, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [4*AW-1:0] pack(input longint c0, input longint c1,
                                             input longint c2, input longint c3);
        logic [AW-1:0] e0, e1, e2, e3;
        e0 = c0[AW-1:0]; e1 = c1[AW-1:0]; e2 = c2[AW-1:0]; e3 = c3[AW-1:0];
        return {e3, e2, e1, e0};
    endfunction

    task automatic model_beat(input logic [31:0] a, input logic [31:0] b,
                              input logic first, input logic half);
        longint av [4];
        longint bv [4];
        longint c [4];
        longint s;
        logic ov;
        for (int i = 0; i < 4; i++) begin
            av[i] = longint'($signed(a[i*DW +: DW]));
            bv[i] = longint'($signed(b[i*DW +: DW]));
        end
        c[0] = av[0] * bv[0] + av[1] * bv[2];
        c[1] = av[0] * bv[1] + av[1] * bv[3];
        c[2] = av[2] * bv[0] + av[3] * bv[2];
        c[3] = av[2] * bv[1] + av[3] * bv[3];
        if (half) begin
            c[0] = 0;
            c[3] = 0;
        end
        ov = first ? 1'b0 : m_ovf;
        for (int i = 0; i < 4; i++) begin
            s = (first ? 64'sd0 : m_acc[i]) + c[i];
            if (s > AMAX) begin s = AMAX; ov = 1'b1; end
            if (s < AMIN) begin s = AMIN; ov = 1'b1; end
            m_acc[i] = s;
        end
        m_ovf = ov;
    endtask

    // Offer one beat until accepted; on acceptance update the model and queue any result
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic first,
                        input logic last, input logic half, input logic use_exp,
                        input logic [4*AW-1:0] exp_c, input logic exp_ovf);
        logic ok;
        int waited;
        exp_t e;
        ok = 1'b0;
        waited = 0;
        A = a; B = b; in_first = first; in_last = last; in_half = half; in_valid = 1'b1;
        while (!ok && waited < 64) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout in_ready=0 for %0d cycles, required 1", waited);
        end else begin
            model_beat(a, b, first, half);
            if (last) begin
                e.c   = use_exp ? exp_c : pack(m_acc[0], m_acc[1], m_acc[2], m_acc[3]);
                e.ovf = use_exp ? exp_ovf : m_ovf;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_narrow();
        int k;
        k = 0;
        while (!nar_out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("narrow_valid", nar_out_valid, 1'b1);
    endtask

    // Scoreboard and hold checks, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid) n_ov_cycles++;
        if (stall_prev) begin
            chk("stall_hold_c", C_out, c_prev);
            chk("stall_hold_ovf", ovf, ovf_prev);
        end
        if (rst && out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
        stall_prev = rst && out_valid && !out_ready;
        c_prev = C_out;
        ovf_prev = ovf;
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output got=%0h expected none", C_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_c", C_out, mon_e.c);
                chk("result_ovf", ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim time expired, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, v0;
        tbl[0] = '{32'h04030201, 32'h08070605, 1'b0, 50, 43, 22, 19, 1'b0};
        tbl[1] = '{32'h04030201, 32'h08070605, 1'b1, 0, 43, 22, 0, 1'b0};
        tbl[2] = '{32'h04030201, 32'h08070605, 1'b0, 50, 43, 22, 19, 1'b0};
        tbl[3] = '{32'h01000001, 32'h08070605, 1'b0, 8, 7, 6, 5, 1'b0};
        tbl[4] = '{32'hFFFEFDFC, 32'h01010101, 1'b0, -3, -3, -7, -7, 1'b0};
        tbl[5] = '{32'h80808080, 32'h7F7F7F7F, 1'b0, -32512, -32512, -32512, -32512, 1'b0};
        tbl[6] = '{32'h02FF0300, 32'hFE040105, 1'b0, -5, 3, -6, 12, 1'b0};
        tbl[7] = '{32'h02FF0300, 32'hFE040105, 1'b1, 0, 3, -6, 0, 1'b0};
        for (int i = 0; i < 4; i++) m_acc[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_nar_in_ready", nar_in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_c_out", C_out, '0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single tile latency: valid exactly three edges after acceptance
        send(32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0, 1'b1, pack(19, 22, 43, 50), 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk((k == 3) ? "latency_hit" : "latency_early", out_valid, (k == 3));
        end
        drain(20);

        // Table of single-tile groups, back-to-back (includes half then full)
        for (int i = 0; i < 8; i++)
            send(tbl[i].a, tbl[i].b, 1'b1, 1'b1, tbl[i].half, 1'b1,
                 pack(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3), tbl[i].ovf);
        drain(20);

        // Four-beat accumulation: one result, valid for one cycle
        n0 = n_out;
        v0 = n_ov_cycles;
        for (int i = 0; i < 4; i++)
            send(32'h04030201, 32'h08070605, (i == 0), (i == 3), 1'b0, 1'b1,
                 pack(76, 88, 172, 200), 1'b0);
        drain(20);
        chk("accum_out_count", n_out - n0, 1);
        chk("accum_valid_cycles", n_ov_cycles - v0, 1);

        // Saturation: wide fits, narrow clamps, then recovers on a new first
        send(32'h80808080, 32'h80808080, 1'b1, 1'b1, 1'b0, 1'b1,
             pack(32768, 32768, 32768, 32768), 1'b0);
        wait_narrow();
        chk("narrow_clamp_c", nar_c, {4{16'h7FFF}});
        chk("narrow_clamp_ovf", nar_ovf, 1'b1);
        drain(20);
        send(32'h80808080, 32'h80808080, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        send(32'h80808080, 32'h80808080, 1'b0, 1'b1, 1'b0, 1'b1,
             pack(65535, 65535, 65535, 65535), 1'b1);
        drain(20);
        send(32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0, 1'b1, pack(19, 22, 43, 50), 1'b0);
        wait_narrow();
        chk("narrow_recover_c", nar_c, {16'd50, 16'd43, 16'd22, 16'd19});
        chk("narrow_recover_ovf", nar_ovf, 1'b0);
        drain(20);

        // Backpressure: results held while out_ready=0 for several cycles
        ready_ctl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n0 = n_out;
        fork
            begin
                send(tbl[6].a, tbl[6].b, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
                send(tbl[4].a, tbl[4].b, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
                send(tbl[3].a, tbl[3].b, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
            end
            begin
                repeat (10) @(posedge clk);
                ready_ctl = 1'b1;
            end
        join
        drain(50);
        chk("bp_out_count", n_out - n0, 3);

        // Reset in the middle of a four-beat group
        for (int i = 0; i < 3; i++)
            send(32'h04030201, 32'h08070605, (i == 0), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_ovf = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_c_out", C_out, '0);
        chk("midrst_ovf", ovf, 1'b0);
        n0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_emit", n_out - n0, 0);
        send(32'h04030201, 32'h08070605, 1'b0, 1'b1, 1'b0, 1'b1, pack(19, 22, 43, 50), 1'b0);
        send(tbl[6].a, tbl[6].b, 1'b1, 1'b1, 1'b0, 1'b1, pack(12, -6, 3, -5), 1'b0);
        drain(20);

        // Random beats, gaps and downstream ready against the model
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'b0, '0, 1'b0);
        end
        rnd_mode = 1'b0;
        ready_ctl = 1'b1;
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strassen_mm2x2_acc.md
# strassen_mm2x2_acc

Pipelined, parametrised 2x2 Strassen matrix-multiply engine with valid/ready flow control and tile accumulation. It is the next generation of the single-cycle SMM datapath. A larger GEMM is streamed through it as a sequence of 2x2 tile products, C += A_k * B_k, framed by first/last flags. It sits between the tile fetch unit (upstream) and the SNN weight/result buffer (downstream).

## Interface
**Parameters**
- DATAWIDTH, 32: signed element width of A and B.
- ACCWIDTH, 2*DATAWIDTH+8: signed accumulator and output element width. Must be at least 2*DATAWIDTH+1.

**Ports**
- clk, in, 1: the only clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- in_valid, in, 1: the input beat is valid.
- in_ready, out, 1: the engine accepts the beat this cycle.
- A, in, 4*DATAWIDTH: signed {a3,a2,a1,a0}. a0=[0][0], a1=[0][1], a2=[1][0], a3=[1][1]; a0 sits at the LSBs.
- B, in, 4*DATAWIDTH: signed {b3,b2,b1,b0}, same layout as A.
- in_first, in, 1: this beat starts a new accumulation group.
- in_last, in, 1: this beat ends the group, and the result is emitted.
- in_half, in, 1: anti-diagonal-only beat. Only c1 and c2 receive a contribution.
- out_valid, out, 1: C_out holds a completed group result.
- out_ready, in, 1: the downstream consumer takes the result.
- C_out, out, 4*ACCWIDTH: signed {c3,c2,c1,c0}, same layout as A.
- ovf, out, 1: one or more saturation events occurred in the emitted group.

## Operation
**Stage 1 (pre-add).** The stage registers, at DATAWIDTH+1 bits, sign-extended:
- T0=a0+a3, T1=a2+a3, T2=a0, T3=a3, T4=a0+a1, T5=a2-a0, T6=a1-a3.
- S0=b0+b3, S1=b0, S2=b1-b3, S3=b2-b0, S4=b3, S5=b0+b1, S6=b2+b3.
- The first/last/half flags travel alongside the data.

**Stage 2 (multiply).** Mi = Ti*Si, registered at full 2*DATAWIDTH+2 bits. When half=1, the stage forces M0, M5 and M6 to 0.

**Stage 3 (post-add + accumulate).** The post-add computes, at 2*DATAWIDTH+4 bits:
- p0=M0+M3-M4+M6
- p1=M2+M4
- p2=M1+M3
- p3=M0-M1+M2+M5
- When half=1, p0 and p3 are 0. The stale-value behaviour of the old design is not kept.

The accumulate step then updates each element:
- acc_i = (first ? 0 : acc_i) + sext(p_i).
- The sum saturates to [-2^(ACCWIDTH-1), 2^(ACCWIDTH-1)-1].
- A sticky ovf_acc is set on any clamp. When first=1, ovf_acc reloads from the current beat only.

**Emit.** On a beat with last=1, the stage loads C_out with the new acc values and ovf with the new ovf_acc, and sets out_valid=1. Beats with last=0 update acc but leave C_out, ovf and out_valid unchanged.

**Flow control.**
- Global enable en = !out_valid || out_ready, and in_ready = rst && en.
- When en=0, every pipeline register and acc holds.
- A beat is accepted when in_valid && in_ready.
- A pipeline bubble carries valid=0 and leaves acc untouched.
- out_valid clears on out_ready unless a new last beat completes in the same cycle. In that case out_valid stays 1 and C_out reloads.

## Timing
- Reset (rst=0 at an edge) clears all stage valids, acc, ovf_acc, C_out, ovf and out_valid to 0. in_ready is 0 while rst=0.
- Reset in mid-operation discards every in-flight beat and any partial group. No output is produced for them.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N+3, with no stall. Throughput is one beat per cycle.
- in_first=1 together with in_last=1 forms a single-tile group.
- in_first=1 on a beat while the previous group has had no last: the partial result of the previous group is discarded silently.
- A group that starts without first after reset accumulates onto 0.
- out_valid=1 with out_ready=0 holds C_out and ovf stable, and the upstream side sees in_ready=0 in the same cycle.
- The flags are sampled only on accepted beats.

## Test plan
1. Single tile, DATAWIDTH=8. A={4,3,2,1}, B={8,7,6,5}, first=last=1 → C_out={50,43,22,19} three cycles after acceptance, ovf=0.
2. Accumulation. The step-1 beat is sent 4 times back-to-back, first on beat 0 and last on beat 3 → exactly one output, {200,172,88,76}, with out_valid high for one cycle while out_ready=1.
3. Half mode. The step-1 operands with in_half=1 → C_out={0,43,22,0}. A following full beat gives {50,43,22,19}, with no residue from the half beat.
4. Saturation. DATAWIDTH=8, ACCWIDTH=17, all A and B elements = -128 → each element is 32768 and fits, ovf=0. With ACCWIDTH=16 → each element clamps to 32767, ovf=1. The next group with first=1 and small operands → ovf=0.
5. Backpressure. Hold out_ready=0 for 5 cycles while results are pending → C_out is stable, in_ready=0, and no beat is lost or duplicated. Continuous random valid/ready must match a golden model.
6. Reset mid-group. Assert rst=0 for 1 cycle after beat 2 of a 4-beat group → all outputs are 0 and no emit occurs. A fresh single-tile group then gives correct results.
